fft_reorder: RTL and testbench

Bit-reversal reorder buffer for the tail of the radix-2 FFT pipeline. It consumes the complex sample stream leaving the last butterfly/twiddle stage, which arrives in bit-reversed index order. It emits the same frame in natural index order. Ping-pong storage keeps a continuous one-sample-per-cycle stream flowing without stalls.

---
 rtl/fft_reorder.sv | 176 +++++++++++++++++
 tb/tb_fft_reorder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_reorder.sv
// Purpose: converts the bit-reversed output of the last FFT stage back to natural index order.
// Latency: natural sample 0 leaves one ce-edge after the last input sample of its frame.
// Backpressure: none; two ping-pong banks absorb a continuous stream, and ce=0 freezes every register.
module fft_reorder #(
    parameter int width = 8,
    parameter int log2n = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    ce,
    input  logic                    valid_i,
    input  logic signed [width-1:0] xr,
    input  logic signed [width-1:0] xi,
    output logic                    valid_o,
    output logic                    sof_o,
    output logic signed [width-1:0] yr,
    output logic signed [width-1:0] yi
);

    localparam int N  = 1 << log2n;
    // Counters keep at least one bit so that a single-entry frame stays legal.
    localparam int CW = (log2n > 0) ? log2n : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef struct packed {
        logic signed [width-1:0] re;
        logic signed [width-1:0] im;
    } sample_t;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    // Reverses the low log2n bits of an index.
    function automatic logic [CW-1:0] bitrev(input logic [CW-1:0] a);
        logic [CW-1:0] r;
        r = '0;
        for (int i = 0; i < log2n; i++) begin
            r[i] = a[log2n-1-i];
        end
        return r;
    endfunction

    // Ping-pong sample storage, deliberately left without reset.
    sample_t mem [2][N];

    // Write side state.
    logic [CW-1:0] wcnt_q;
    logic          wbank_q;
    logic          wr_fire;
    logic          wr_last;

    // Bank-full flags, one per bank.
    logic [1:0]    ready_q;

    // Read side state and next-state terms.
    state_t        state_q, state_d;
    logic [CW-1:0] rcnt_q, rcnt_d;
    logic          rbank_q, rbank_d;
    logic          rd_en;
    logic [CW-1:0] rd_addr;
    logic          rd_clr;
    logic          valid_d;
    logic          sof_d;
    sample_t       rd_dat;

    assign wr_fire = ce & valid_i;
    assign wr_last = wr_fire & (wcnt_q == LAST);

    // Store incoming samples at their bit-reversed slot in the bank being filled.
    always_ff @(posedge CLK) begin
        if (RST && wr_fire) begin
            mem[wbank_q][bitrev(wcnt_q)] <= {xr, xi};
        end
    end

    // Advance the write index, flipping banks at the end of each frame.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            wcnt_q  <= '0;
            wbank_q <= 1'b0;
        end else if (wr_fire) begin
            if (wcnt_q == LAST) begin
                wcnt_q  <= '0;
                wbank_q <= ~wbank_q;
            end else begin
                wcnt_q <= wcnt_q + 1'b1;
            end
        end
    end

    // Writer marks a bank full, reader releases it; they never target the same bank on one edge.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            ready_q <= 2'b00;
        end else if (ce) begin
            for (int b = 0; b < 2; b++) begin
                if (wr_last && (wbank_q == b[0])) begin
                    ready_q[b] <= 1'b1;
                end else if (rd_clr && (rbank_q == b[0])) begin
                    ready_q[b] <= 1'b0;
                end
            end
        end
    end

    // Read sequencer: start a bank when it is full, stream N entries, then hand over.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        rbank_d = rbank_q;
        rd_en   = 1'b0;
        rd_addr = rcnt_q;
        rd_clr  = 1'b0;
        valid_d = 1'b0;
        sof_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ready_q[rbank_q]) begin
                    rd_en   = 1'b1;
                    rd_addr = '0;
                    valid_d = 1'b1;
                    sof_d   = 1'b1;
                    if (N == 1) begin
                        rd_clr  = 1'b1;
                        rbank_d = ~rbank_q;
                    end else begin
                        rcnt_d  = CW'(1);
                        state_d = READ;
                    end
                end
            end
            READ: begin
                rd_en   = 1'b1;
                valid_d = 1'b1;
                rcnt_d  = rcnt_q + 1'b1;
                if (rcnt_q == LAST) begin
                    rd_clr  = 1'b1;
                    rbank_d = ~rbank_q;
                    rcnt_d  = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rd_dat = mem[rbank_q][rd_addr];

    // Register the sequencer state and the output sample; data holds while nothing is read.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            rcnt_q  <= '0;
            rbank_q <= 1'b0;
            valid_o <= 1'b0;
            sof_o   <= 1'b0;
            yr      <= '0;
            yi      <= '0;
        end else if (ce) begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            rbank_q <= rbank_d;
            valid_o <= valid_d;
            sof_o   <= sof_d;
            if (rd_en) begin
                yr <= rd_dat.re;
                yi <= rd_dat.im;
            end
        end
    end

endmodule

// File: tb/tb_fft_reorder.sv
module tb_fft_reorder;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic ce = 1'b0;
    logic valid2 = 1'b0;
    logic valid3 = 1'b0;
    logic signed [7:0] xr = '0;
    logic signed [7:0] xi = '0;
    logic vo2, so2, vo3, so3;
    logic signed [7:0] yr2, yi2, yr3, yi3;

    fft_reorder #(.width(8), .log2n(2)) dut4 (
        .CLK(CLK), .RST(RST), .ce(ce), .valid_i(valid2), .xr(xr), .xi(xi),
        .valid_o(vo2), .sof_o(so2), .yr(yr2), .yi(yi2)
    );

    fft_reorder #(.width(8), .log2n(3)) dut8 (
        .CLK(CLK), .RST(RST), .ce(ce), .valid_i(valid3), .xr(xr), .xi(xi),
        .valid_o(vo3), .sof_o(so3), .yr(yr3), .yi(yi3)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass = 0;

    // Reference model, index 0 = 4-point instance, index 1 = 8-point instance.
    int fill [2];
    int bre [2][8];
    int bim [2][8];
    int qre [2][64];
    int qim [2][64];
    int qsof [2][64];
    int qh [2];
    int qt [2];
    int left [2];
    int ev [2];
    int es [2];
    int ere [2];
    int eim [2];

    function automatic int npts(input int d);
        return (d != 0) ? 8 : 4;
    endfunction

    function automatic int nbits(input int d);
        return (d != 0) ? 3 : 2;
    endfunction

    function automatic int rev(input int k, input int bits);
        int r;
        int v;
        r = 0;
        v = k;
        for (int i = 0; i < bits; i++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            fill[d] = 0; qh[d] = 0; qt[d] = 0; left[d] = 0;
            ev[d] = 0; es[d] = 0; ere[d] = 0; eim[d] = 0;
        end
    endtask

    // One active edge: emit the next reordered sample if a frame completed earlier, then absorb input.
    task automatic model_edge(input int d, input logic v, input int re, input int im);
        int n;
        int idx;
        n = npts(d);
        ev[d] = 0;
        es[d] = 0;
        if (left[d] > 0 || (qt[d] - qh[d]) >= n) begin
            if (left[d] == 0) left[d] = n;
            idx = qh[d] % 64;
            ere[d] = qre[d][idx];
            eim[d] = qim[d][idx];
            es[d] = qsof[d][idx];
            ev[d] = 1;
            qh[d]++;
            left[d]--;
        end
        if (v) begin
            bre[d][fill[d]] = re;
            bim[d][fill[d]] = im;
            fill[d]++;
            if (fill[d] == n) begin
                for (int k = 0; k < n; k++) begin
                    idx = qt[d] % 64;
                    qre[d][idx] = bre[d][rev(k, nbits(d))];
                    qim[d][idx] = bim[d][rev(k, nbits(d))];
                    qsof[d][idx] = (k == 0) ? 1 : 0;
                    qt[d]++;
                end
                fill[d] = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic signed [31:0] got, input int exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_all();
        chk("n4_valid", vo2, ev[0]);
        chk("n4_sof", so2, es[0]);
        chk("n4_yr", yr2, ere[0]);
        chk("n4_yi", yi2, eim[0]);
        chk("n8_valid", vo3, ev[1]);
        chk("n8_sof", so3, es[1]);
        chk("n8_yr", yr3, ere[1]);
        chk("n8_yi", yi3, eim[1]);
    endtask

    task automatic step(input logic v2i, input logic v3i, input int re, input int im);
        valid2 = v2i;
        valid3 = v3i;
        xr = 8'(re);
        xi = 8'(im);
        @(posedge CLK);
        if (!RST) model_reset();
        else if (ce) begin
            model_edge(0, v2i, re, im);
            model_edge(1, v3i, re, im);
        end
        #1;
        check_all();
    endtask

    int sf_r [4];
    int rs_r [4];
    int o8 [8];

    initial begin
        sf_r = '{10, 30, 20, 40};
        rs_r = '{1, 3, 2, 4};
        o8 = '{0, 4, 2, 6, 1, 5, 3, 7};
        model_reset();

        // Reset state
        RST = 1'b0; ce = 1'b1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        RST = 1'b1;
        step(0, 0, 0, 0);

        // Single frame, N=4
        for (int i = 1; i <= 4; i++) step(1, 0, 10 * i, -10 * i);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0);
            chk("single_yr", yr2, sf_r[k]);
            chk("single_yi", yi2, -sf_r[k]);
            chk("single_sof", so2, (k == 0) ? 1 : 0);
        end
        step(0, 0, 0, 0);
        chk("single_drain_valid", vo2, 0);

        // Back-to-back stream of five frames
        for (int i = 0; i < 20; i++) step(1, 0, i, $urandom_range(0, 255) - 128);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);

        // Gappy input
        for (int i = 1; i <= 4; i++) begin
            step(1, 0, 10 * i, -10 * i);
            if (i < 4) step(0, 0, 99, 99);
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0);
            chk("gappy_yr", yr2, sf_r[k]);
            chk("gappy_valid", vo2, 1);
        end
        step(0, 0, 0, 0);

        // ce stall in the middle of readout
        for (int i = 1; i <= 4; i++) step(1, 0, 5 * i, 7 * i);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 77, 77);
            chk("stall_yr", yr2, 15);
        end
        ce = 1'b1;
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

        // Reset mid-frame, with ce low to show reset is not gated
        step(1, 0, 50, 51);
        step(1, 0, 60, 61);
        RST = 1'b0; ce = 1'b0;
        step(0, 0, 0, 0);
        chk("rst_yr", yr2, 0);
        chk("rst_valid", vo2, 0);
        RST = 1'b1; ce = 1'b1;
        for (int i = 1; i <= 4; i++) step(1, 0, i, -i);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0);
            chk("rst_frame_yr", yr2, rs_r[k]);
            chk("rst_frame_sof", so2, (k == 0) ? 1 : 0);
        end
        step(0, 0, 0, 0);

        // log2n=3 single frame
        for (int i = 0; i < 8; i++) step(0, 1, i, 100 - i);
        for (int k = 0; k < 8; k++) begin
            step(0, 0, 0, 0);
            chk("n8_order", yr3, o8[k]);
        end
        step(0, 0, 0, 0);

        // Randomized traffic on both instances with random ce
        for (int i = 0; i < 400; i++) begin
            ce = ($urandom_range(0, 7) != 0);
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128);
        end
        ce = 1'b1;
        for (int i = 0; i < 24; i++) step(0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
